// File: rtl/serial_right_shifter.sv
`default_nettype none
// ============================================================================
// Module   : serial_right_shifter
// Brief    : Bit-serial logical/arithmetic right shifter, one position per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module serial_right_shifter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] shift_amt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_out,
    output logic             shift_out
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_SHIFT   = 2'd1;
    localparam logic [1:0]       c_DONE    = 2'd2;
    localparam logic [AMT_W-1:0] c_CNT_ONE = AMT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [AMT_W-1:0] r_count;
    logic             r_arith;
    logic [WIDTH-1:0] r_q;
    logic             r_shift_out;
    logic             r_busy;
    logic             r_done;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_fill;

    assign w_fill = r_arith & r_q[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = (shift_amt != '0) ? c_SHIFT : c_DONE;
                end
            end
            c_SHIFT: begin
                if (r_count == c_CNT_ONE) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Flags are registered from the current state, so they trail it by one cycle.
    always_comb begin
        w_busy_nxt = (r_state == c_SHIFT);
        w_done_nxt = (r_state == c_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q         <= '0;
            r_shift_out <= 1'b0;
            r_count     <= '0;
            r_arith     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_q         <= data_in;
                        r_shift_out <= 1'b0;
                        r_count     <= shift_amt;
                        r_arith     <= arith;
                    end
                end
                c_SHIFT: begin
                    r_q         <= {w_fill, r_q[WIDTH-1:1]};
                    r_shift_out <= r_q[0];
                    r_count     <= r_count - c_CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign q_out     = r_q;
    assign shift_out = r_shift_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_right_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_right_shifter
// Brief    : Directed vector bench for serial_right_shifter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_right_shifter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] data_in;
    logic [2:0] shift_amt;
    logic       arith;
    logic       busy;
    logic       done;
    logic [7:0] q_out;
    logic       shift_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] d;
        logic [2:0] amt;
        logic       ar;
        logic [7:0] exp_q;
        logic       exp_so;
    } vec_t;

    vec_t vecs[10];

    serial_right_shifter #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .data_in   (data_in),
        .shift_amt (shift_amt),
        .arith     (arith),
        .busy      (busy),
        .done      (done),
        .q_out     (q_out),
        .shift_out (shift_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Starts an operation, scrambles inputs after capture, waits for done.
    task automatic run_op(input logic [7:0] d, input logic [2:0] a, input logic ar,
                          output int lat, output int bcnt, output int both);
        data_in = d; shift_amt = a; arith = ar; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; data_in = ~d; shift_amt = a + 3'd1; arith = ~ar;
        lat = -1; bcnt = 0; both = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (busy && done) both++;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat, bcnt, both, dcnt;
        logic [7:0] held;

        vecs[0] = '{8'hB4, 3'd3, 1'b0, 8'h16, 1'b1};
        vecs[1] = '{8'hB4, 3'd3, 1'b1, 8'hF6, 1'b1};
        vecs[2] = '{8'hB4, 3'd0, 1'b0, 8'hB4, 1'b0};
        vecs[3] = '{8'hB4, 3'd0, 1'b1, 8'hB4, 1'b0};
        vecs[4] = '{8'h80, 3'd7, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{8'h80, 3'd7, 1'b0, 8'h01, 1'b0};
        vecs[6] = '{8'h7F, 3'd7, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h01, 3'd1, 1'b0, 8'h00, 1'b1};
        vecs[8] = '{8'hC3, 3'd2, 1'b1, 8'hF0, 1'b1};
        vecs[9] = '{8'hA5, 3'd4, 1'b0, 8'h0A, 1'b0};

        reset_n = 1'b0; start = 1'b1; data_in = 8'hFF; shift_amt = 3'd5; arith = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_q", q_out, 8'h00);
        chk("reset_so", shift_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        start = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].d, vecs[i].amt, vecs[i].ar, lat, bcnt, both);
            chk($sformatf("v%0d_latency", i), lat, int'(vecs[i].amt) + 1);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, int'(vecs[i].amt));
            chk($sformatf("v%0d_busy_and_done", i), both, 0);
            chk($sformatf("v%0d_q", i), q_out, vecs[i].exp_q);
            chk($sformatf("v%0d_so", i), shift_out, vecs[i].exp_so);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_width", i), done, 0);
        end

        // Result holds in IDLE; a reset_n glitch between edges is invisible.
        held = q_out;
        data_in = 8'h3C;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_hold_q", q_out, held);
        chk("idle_hold_so", shift_out, 0);

        // Second start during SHIFT must be ignored.
        data_in = 8'hB4; shift_amt = 3'd3; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        data_in = 8'h55; shift_amt = 3'd1; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 3; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        chk("restart_latency", lat, 4);
        chk("restart_q", q_out, 8'h16);
        chk("restart_so", shift_out, 1);
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("restart_single_done", dcnt, 0);

        // Reset mid-SHIFT aborts with no done pulse.
        data_in = 8'hB4; shift_amt = 3'd3; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("abort_q", q_out, 8'h00);
        chk("abort_so", shift_out, 0);
        chk("abort_busy", busy, 0);
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", dcnt, 0);
        run_op(8'hB4, 3'd3, 1'b1, lat, bcnt, both);
        chk("post_abort_latency", lat, 4);
        chk("post_abort_q", q_out, 8'hF6);
        chk("post_abort_so", shift_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
